// File: rtl/mmio_console_pkg.sv
// Shared constants for the memory-mapped console/halt peripheral: default
// register addresses and status-word bit positions.
package mmio_console_pkg;

    localparam logic [31:0] CONSOLE_ADDR_DEF = 32'h0000_FFF0;
    localparam logic [31:0] HALT_ADDR_DEF    = 32'h0000_FFF4;
    localparam logic [31:0] STATUS_ADDR_DEF  = 32'h0000_FFF8;

    localparam int unsigned STAT_OVF   = 31;
    localparam int unsigned STAT_HALT  = 30;
    localparam int unsigned STAT_FULL  = 29;
    localparam int unsigned STAT_EMPTY = 28;

endpackage

// File: rtl/mmio_console_sync_fifo.sv
// Synchronous FIFO with registered count; push while full is accepted only
// when a pop happens in the same cycle, otherwise over/underflow requests are no-ops.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    // Head is forced to zero while empty so the stream data is clean out of reset.
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_console.sv
// Console/halt peripheral on the core data bus: decodes stores to the console,
// halt and status addresses, buffers console bytes and latches the first halt code.
module mmio_console
    import mmio_console_pkg::*;
#(
    parameter int unsigned DEPTH        = 8,
    parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEF,
    parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEF,
    parameter logic [31:0] STATUS_ADDR  = STATUS_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic        hit,
    output logic [31:0] readdata,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        halted,
    output logic [31:0] halt_code,
    output logic        overflow
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          sel_console;
    logic          sel_halt;
    logic          sel_status;
    logic          push;
    logic          pop;
    logic          halt_store;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status;

    assign sel_console = (dataadr == CONSOLE_ADDR);
    assign sel_halt    = (dataadr == HALT_ADDR);
    assign sel_status  = (dataadr == STATUS_ADDR);
    assign hit         = sel_console | sel_halt | sel_status;

    assign push       = memwrite & sel_console & ~halted;
    assign halt_store = memwrite & sel_halt & ~halted;
    assign out_valid  = ~fifo_empty;
    assign pop        = out_valid & out_ready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (writedata[7:0]),
        .pop   (pop),
        .dout  (out_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // Status word assembly; reads are side-effect free.
    always_comb begin
        status             = '0;
        status[CW-1:0]     = fifo_count;
        status[STAT_OVF]   = overflow;
        status[STAT_HALT]  = halted;
        status[STAT_FULL]  = fifo_full;
        status[STAT_EMPTY] = fifo_empty;
    end

    assign readdata = sel_status ? status : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            halted    <= 1'b0;
            halt_code <= '0;
            overflow  <= 1'b0;
        end else begin
            if (halt_store) begin
                halted    <= 1'b1;
                halt_code <= writedata;
            end
            // A drop only happens when full and nothing leaves in the same cycle.
            if (push & fifo_full & ~pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mmio_console.sv
// Directed self-checking bench for mmio_console: FIFO push/drain, overflow,
// full push+pop, halt latching, status reads and reset clearing.
module tb_mmio_console;
    import mmio_console_pkg::*;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        hit;
    logic [31:0] readdata;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        halted;
    logic [31:0] halt_code;
    logic        overflow;

    int checks;
    int errors;

    mmio_console dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .hit       (hit),
        .readdata  (readdata),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .halted    (halted),
        .halt_code (halt_code),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
        tick();
        memwrite  = 1'b0;
        dataadr   = 32'h0;
        writedata = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        memwrite = 1'b0; dataadr = 32'h0; writedata = 32'h0; out_ready = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_stream: valid=%b data=%h, want 0/00", out_valid, out_data);
        end
        checks++;
        if (halted !== 1'b0 || halt_code !== 32'h0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: halted=%b code=%h ovf=%b, want 0", halted, halt_code, overflow);
        end
        dataadr = STATUS_ADDR_DEF;
        #1;
        checks++;
        if (readdata !== 32'h1000_0000) begin
            errors++;
            $display("FAIL reset_status: got %h want 10000000", readdata);
        end
        dataadr = 32'h0;
    endtask

    task automatic test_single_push();
        store(CONSOLE_ADDR_DEF, 32'h0000_0148);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h48) begin
            errors++;
            $display("FAIL single_push: valid=%b data=%h, want 1/48", out_valid, out_data);
        end
        dataadr = STATUS_ADDR_DEF;
        #1;
        checks++;
        if (readdata !== 32'h0000_0001 || hit !== 1'b1) begin
            errors++;
            $display("FAIL single_status: rd=%h hit=%b, want 00000001/1", readdata, hit);
        end
        dataadr   = 32'h0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp [8];
        for (int i = 0; i < 8; i++) store(CONSOLE_ADDR_DEF, 32'(8'h10 + i));
        memwrite  = 1'b1;
        dataadr   = CONSOLE_ADDR_DEF;
        writedata = 32'h0000_00AA;
        out_ready = 1'b1;
        tick();
        memwrite  = 1'b0;
        dataadr   = STATUS_ADDR_DEF;
        #1;
        checks++;
        if (readdata !== 32'h2000_0008 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fullpp_status: rd=%h ovf=%b, want 20000008/0", readdata, overflow);
        end
        dataadr = 32'h0;
        for (int i = 0; i < 7; i++) exp[i] = 8'(8'h11 + i);
        exp[7] = 8'hAA;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp[i]) begin
                errors++;
                $display("FAIL fullpp_drain[%0d]: valid=%b data=%h, want 1/%h", i, out_valid, out_data, exp[i]);
            end
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fullpp_empty: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) begin
            store(CONSOLE_ADDR_DEF, 32'(i));
            if (i == 8) begin
                checks++;
                if (overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_early: ovf=%b want 0 after 8 pushes", overflow);
                end
            end
        end
        dataadr = STATUS_ADDR_DEF;
        #1;
        checks++;
        if (readdata !== 32'hA000_0008 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_status: rd=%h ovf=%b, want a0000008/1", readdata, overflow);
        end
        dataadr   = 32'h0;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
                errors++;
                $display("FAIL ovf_drain[%0d]: valid=%b data=%h, want 1/%h", i, out_valid, out_data, 8'(i));
            end
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_after: valid=%b ovf=%b, want 0/1", out_valid, overflow);
        end
    endtask

    task automatic test_status();
        store(CONSOLE_ADDR_DEF, 32'h21);
        store(CONSOLE_ADDR_DEF, 32'h22);
        store(CONSOLE_ADDR_DEF, 32'h23);
        dataadr = STATUS_ADDR_DEF;
        #1;
        checks++;
        if (readdata !== 32'h8000_0003 || hit !== 1'b1) begin
            errors++;
            $display("FAIL status_read: rd=%h hit=%b, want 80000003/1", readdata, hit);
        end
        dataadr = 32'h0000_0010;
        #1;
        checks++;
        if (readdata !== 32'h0 || hit !== 1'b0) begin
            errors++;
            $display("FAIL status_miss: rd=%h hit=%b, want 0/0", readdata, hit);
        end
        memwrite = 1'b1; dataadr = 32'h0000_FFFC; writedata = 32'h77;
        #1;
        checks++;
        if (hit !== 1'b0) begin
            errors++;
            $display("FAIL miss_store_hit: hit=%b want 0", hit);
        end
        tick();
        dataadr = STATUS_ADDR_DEF; writedata = 32'h66;
        #1;
        checks++;
        if (hit !== 1'b1) begin
            errors++;
            $display("FAIL status_store_hit: hit=%b want 1", hit);
        end
        tick();
        memwrite = 1'b0;
        #1;
        checks++;
        if (readdata !== 32'h8000_0003 || out_data !== 8'h21) begin
            errors++;
            $display("FAIL status_nochange: rd=%h head=%h, want 80000003/21", readdata, out_data);
        end
        dataadr   = 32'h0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        out_ready = 1'b0;
    endtask

    task automatic test_halt();
        do_reset();
        store(HALT_ADDR_DEF, 32'hDEAD_BEEF);
        checks++;
        if (halted !== 1'b1 || halt_code !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL halt_first: halted=%b code=%h, want 1/deadbeef", halted, halt_code);
        end
        store(HALT_ADDR_DEF, 32'h0000_0001);
        store(CONSOLE_ADDR_DEF, 32'h0000_0055);
        checks++;
        if (halt_code !== 32'hDEAD_BEEF || out_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL halt_sticky: code=%h valid=%b ovf=%b, want deadbeef/0/0", halt_code, out_valid, overflow);
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        for (int i = 0; i < 5; i++) store(CONSOLE_ADDR_DEF, 32'(8'h30 + i));
        store(HALT_ADDR_DEF, 32'h0000_0042);
        dataadr = STATUS_ADDR_DEF;
        #1;
        checks++;
        if (readdata !== 32'h4000_0005) begin
            errors++;
            $display("FAIL prereset_status: rd=%h want 40000005", readdata);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || readdata !== 32'h1000_0000 || halted !== 1'b0 ||
            halt_code !== 32'h0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b rd=%h halted=%b code=%h ovf=%b, want 0/10000000/0/0/0",
                     out_valid, readdata, halted, halt_code, overflow);
        end
        dataadr = 32'h0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_push();
        test_full_push_pop();
        test_overflow();
        test_status();
        test_halt();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
